// File: rtl/fc_port_state_rx.sv
// Fibre Channel port-state receive tracker.
// Each channel decodes incoming ordered sets, recognises primitive sequences
// after a run of identical ordered sets, and walks the port-state machine
// (AC / LR2 / LR3 / LF1 / LF2 / OL1 / OL2 / OL3). Loss of word sync for long
// enough forces link failure. An idle hold-off delays is_active after entry
// into AC. Channels share nothing but the clock and the reset.

package fc;

  // Port states. OL1 and OL3 are entered only by external means (not by
  // this receiver) but are still honoured when they appear in the register.
  typedef enum logic [2:0] {
    STATE_AC  = 3'd0,
    STATE_LR2 = 3'd1,
    STATE_LR3 = 3'd2,
    STATE_LF1 = 3'd3,
    STATE_LF2 = 3'd4,
    STATE_OL1 = 3'd5,
    STATE_OL2 = 3'd6,
    STATE_OL3 = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    PRIM_NONE  = 3'd0,
    PRIM_IDLE  = 3'd1,
    PRIM_ARBFF = 3'd2,
    PRIM_OLS   = 3'd3,
    PRIM_NOS   = 3'd4,
    PRIM_LR    = 3'd5,
    PRIM_LRR   = 3'd6
  } prim_t;

  // Ordered-set encodings: K28.5 in the most significant byte followed by
  // three data characters, as delivered by the 8b/10b decoder.
  localparam logic [31:0] OS_IDLE  = 32'hBC95_B5B5;  // K28.5 D21.4 D21.5 D21.5
  localparam logic [31:0] OS_ARBFF = 32'hBC94_9F9F;  // K28.5 D20.4 D31.4 D31.4
  localparam logic [31:0] OS_OLS   = 32'hBC35_8A55;  // K28.5 D21.1 D10.4 D21.2
  localparam logic [31:0] OS_NOS   = 32'hBC55_BF45;  // K28.5 D21.2 D31.5 D5.2
  localparam logic [31:0] OS_LR    = 32'hBC49_BF49;  // K28.5 D9.2  D31.5 D9.2
  localparam logic [31:0] OS_LRR   = 32'hBC35_BF49;  // K28.5 D21.1 D31.5 D9.2

  function automatic prim_t map_primitive(input logic [31:0] word);
    prim_t p;
    case (word)
      OS_IDLE:  p = PRIM_IDLE;
      OS_ARBFF: p = PRIM_ARBFF;
      OS_OLS:   p = PRIM_OLS;
      OS_NOS:   p = PRIM_NOS;
      OS_LR:    p = PRIM_LR;
      OS_LRR:   p = PRIM_LRR;
      default:  p = PRIM_NONE;
    endcase
    return p;
  endfunction

  // Primitives that must repeat before they are acted upon.
  function automatic logic is_sequence(input prim_t p);
    return (p == PRIM_OLS) || (p == PRIM_NOS) || (p == PRIM_LR) || (p == PRIM_LRR);
  endfunction

endpackage

module fc_port_state_rx #(
  parameter int NUM_CH           = 1,
  parameter int SEQ_MATCH        = 3,
  parameter int IDLE_HOLD_OFF    = 6,
  parameter int SYNC_LOSS_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [32*NUM_CH-1:0]                 data,
  input  logic [4*NUM_CH-1:0]                  datak,
  input  logic [NUM_CH-1:0]                    sync,
  output logic [NUM_CH*$bits(fc::state_t)-1:0] state,
  output logic [NUM_CH-1:0]                    is_active,
  output logic [NUM_CH-1:0]                    state_change
);

  localparam int SW     = $bits(fc::state_t);
  localparam int RUN_W  = $clog2(SEQ_MATCH + 1);
  localparam int LOSS_W = $clog2(SYNC_LOSS_CYCLES + 1);
  // A zero hold-off still needs a one-bit counter to keep the logic uniform.
  localparam int HOLD_W = (IDLE_HOLD_OFF == 0) ? 1 : $clog2(IDLE_HOLD_OFF + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(SEQ_MATCH);
  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(SYNC_LOSS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(IDLE_HOLD_OFF);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

    logic [31:0]       word;
    logic [3:0]        kflags;
    logic              sync_bit;
    logic              is_os;
    fc::prim_t         prim;

    fc::prim_t         run_prim_q, run_prim_d;
    logic [RUN_W-1:0]  run_cnt_q,  run_cnt_d;
    logic              seq_hit;

    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
    logic              loss_trip;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    fc::state_t        state_q, state_d;
    logic              change_q;
    logic              active;

    assign word     = data[32*ch +: 32];
    assign kflags   = datak[4*ch +: 4];
    assign sync_bit = sync[ch];

    // Decode the current word into a primitive; only K-in-MSB words with sync count.
    always_comb begin
      // NOTE: every signal written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      is_os = sync_bit && (kflags == 4'b1000);
      prim  = is_os ? fc::map_primitive(word) : fc::PRIM_NONE;
    end

    // Track runs of identical sequence primitives, saturating at SEQ_MATCH.
    always_comb begin
      run_prim_d = run_prim_q;
      run_cnt_d  = '0;
      if (fc::is_sequence(prim)) begin
        if ((prim == run_prim_q) && (run_cnt_q != '0)) begin
          run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_W'(1);
        end else begin
          run_cnt_d  = RUN_W'(1);
          run_prim_d = prim;
        end
      end
      seq_hit = (run_cnt_d == RUN_MAX);
    end

    // Count consecutive cycles without sync and flag the cycle the limit is hit.
    always_comb begin
      if (sync_bit) begin
        loss_cnt_d = '0;
      end else if (loss_cnt_q == LOSS_MAX) begin
        loss_cnt_d = loss_cnt_q;
      end else begin
        loss_cnt_d = loss_cnt_q + LOSS_W'(1);
      end
      loss_trip = !sync_bit && (loss_cnt_d == LOSS_MAX);
    end

    // Idle hold-off: reload outside AC, count down to zero while in AC.
    always_comb begin
      if (state_q != fc::STATE_AC) begin
        hold_cnt_d = HOLD_MAX;
      end else if (hold_cnt_q == '0) begin
        hold_cnt_d = hold_cnt_q;
      end else begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
    end

    // Next-state logic: recognised primitives, then sync-loss override.
    always_comb begin
      state_d = state_q;
      if (seq_hit) begin
        unique case (prim)
          fc::PRIM_OLS: state_d = fc::STATE_OL2;
          fc::PRIM_NOS: state_d = fc::STATE_LF1;
          fc::PRIM_LR: begin
            if ((state_q == fc::STATE_OL3) || (state_q == fc::STATE_LF2)) state_d = fc::STATE_LF2;
            else                                                           state_d = fc::STATE_LR2;
          end
          fc::PRIM_LRR: begin
            unique case (state_q)
              fc::STATE_LF1, fc::STATE_LF2, fc::STATE_OL1: state_d = state_q;
              fc::STATE_OL3:                               state_d = fc::STATE_LF2;
              default:                                     state_d = fc::STATE_LR3;
            endcase
          end
          default: state_d = state_q;
        endcase
      end else if ((prim == fc::PRIM_IDLE) || (prim == fc::PRIM_ARBFF)) begin
        unique case (state_q)
          fc::STATE_LR2, fc::STATE_LR3: state_d = fc::STATE_AC;
          fc::STATE_OL3:                state_d = fc::STATE_OL2;
          default:                      state_d = state_q;
        endcase
      end
      if (loss_trip) begin
        state_d = fc::STATE_LF1;
      end
    end

    // State register with registered change pulse aligned to the new state.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
        state_q  <= fc::STATE_LF2;
        change_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        change_q <= (state_d != state_q);
      end
    end

    // Run, sync-loss and hold-off counters; reset discards all progress.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        run_prim_q <= fc::PRIM_NONE;
        run_cnt_q  <= '0;
        loss_cnt_q <= '0;
        hold_cnt_q <= HOLD_MAX;
      end else begin
        run_prim_q <= run_prim_d;
        run_cnt_q  <= run_cnt_d;
        loss_cnt_q <= loss_cnt_d;
        hold_cnt_q <= hold_cnt_d;
      end
    end

    // Output decode: active once in AC and the hold-off has run out.
    always_comb begin
      active = (state_q == fc::STATE_AC) && (hold_cnt_q == '0);
    end

    assign state[SW*ch +: SW] = state_q;
    assign is_active[ch]      = active;
    assign state_change[ch]   = change_q;

  end

endmodule

// File: doc/fc_port_state_rx.md
FC_PORT_STATE_RX -- requirements
Module: fc_port_state_rx

Interface
REQ-001 Parameter NUM_CH, default 1, number of independent FC receive channels (1..8).
REQ-002 Parameter SEQ_MATCH, default 3, consecutive identical ordered sets needed to recognise a primitive sequence (1..15).
REQ-003 Parameter IDLE_HOLD_OFF, default 6, cycles in STATE_AC before is_active asserts (0..255).
REQ-004 Parameter SYNC_LOSS_CYCLES, default 1024, consecutive cycles of sync low before forced link failure (1..2^20).
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 data  input  32*NUM_CH  received word; channel i at bits [32i+31:32i].
REQ-008 datak  input  4*NUM_CH  K-flags; channel i at bits [4i+3:4i].
REQ-009 sync  input  NUM_CH  per-channel word-sync-good from decoder.
REQ-010 state  output  NUM_CH*$bits(fc::state_t)  registered per-channel fc::state_t.
REQ-011 is_active  output  NUM_CH  channel active and idle hold-off expired.
REQ-012 state_change  output  NUM_CH  one-cycle pulse when channel state register changes.

Function
REQ-013 Channels SHALL be fully independent; no shared state between channels.
REQ-014 A word SHALL be an ordered set only when its datak equals 4'b1000 and its sync bit is high; primitive decoded with fc::map_primitive(data).
REQ-015 Sequence primitives SHALL be OLS, NOS, LR, LRR; each is recognised only on the SEQ_MATCH-th consecutive identical ordered set, with the run counter saturating so a continuing run keeps it recognised on every word.
REQ-016 A different sequence primitive SHALL restart the run counter at 1; any non-ordered-set word, any other primitive, or sync low SHALL clear it to 0.
REQ-017 IDLE and ARBFF SHALL be recognised on a single ordered set (no run requirement).
REQ-018 Recognised OLS: any state -> OL2.
REQ-019 Recognised NOS: any state -> LF1.
REQ-020 Recognised LR: OL3 or LF2 -> LF2; all others -> LR2.
REQ-021 Recognised LRR: LF1, LF2, OL1 hold; OL3 -> LF2; all others -> LR3.
REQ-022 Recognised IDLE/ARBFF: LR2, LR3 -> AC; OL3 -> OL2; all others hold.
REQ-023 Unrecognised words SHALL leave state unchanged.
REQ-024 State register SHALL update on the clk edge sampling the recognising word (one-cycle latency to state output).
REQ-025 Per-channel sync-loss counter SHALL increment while sync low, clear when sync high, saturate at SYNC_LOSS_CYCLES.
REQ-026 On the cycle the sync-loss counter reaches SYNC_LOSS_CYCLES, state SHALL be forced to LF1, overriding any primitive transition; state then holds LF1 while sync stays low.
REQ-027 Hold-off counter SHALL load IDLE_HOLD_OFF whenever state is not AC, decrement by 1 per cycle in AC, stop at 0.
REQ-028 is_active SHALL equal (state == AC) and (hold-off counter == 0); with IDLE_HOLD_OFF = 0 it asserts the same cycle state becomes AC.
REQ-029 Leaving AC SHALL deassert is_active the same cycle state changes and reload the counter.
REQ-030 state_change SHALL be registered, high exactly one cycle, coincident with the new state value appearing on state.
REQ-031 Counter widths SHALL be $clog2(parameter+1); no wrap-around permitted.

Reset
REQ-032 While reset_n low at a clk edge: state = STATE_LF2, is_active = 0, state_change = 0, run counters = 0, sync-loss counters = 0, hold-off counters = IDLE_HOLD_OFF, all channels.
REQ-033 Reset asserted mid-run or mid-hold-off SHALL discard all progress; first post-reset word is treated as first of a new run.

Verification
REQ-034 NUM_CH=1, LF2 state, 3 consecutive LR then LRR x3 then IDLE -> state LF2 after LR, LF2 held through LRR, LF2 held on IDLE; state_change never pulses.
REQ-035 From AC: NOS, NOS, data word (datak 0000), NOS -> no change; further NOS x2 -> LF1 on 3rd consecutive NOS, state_change 1 cycle, is_active drops same cycle.
REQ-036 From LR2: single IDLE -> AC next cycle; is_active asserts exactly 6 cycles later; IDLE_HOLD_OFF=0 build -> is_active same cycle as AC.
REQ-037 From AC, SYNC_LOSS_CYCLES=16: sync low 15 cycles then high -> stays AC; sync low 16 cycles -> LF1 on 16th; OLS x3 during sync low ignored.
REQ-038 NUM_CH=2: channel 0 receives OLS x3, channel 1 IDLE stream in AC -> ch0 OL2, ch1 stays AC and is_active 1; reset_n low 1 cycle mid-stream -> both LF2, is_active 0.
